// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite bus bundle used between the interconnect and register endpoints.
// 32-bit address/data; slave modport is the endpoint view.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wlast, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rlast, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wlast, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rlast, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register endpoint: NUM_RW control registers plus NUM_RO status words.
// Define AXI_REGS_DECERR_EN to answer writes to RO/unmapped words with SLVERR.
module axi_lite_reg_slave #(
    parameter int NUM_RW = 4,
    parameter int NUM_RO = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_lite_if.slave             axi,
    output logic [NUM_RW*32-1:0]  reg_out,
    output logic [NUM_RW-1:0]     reg_wr_pulse,
    input  logic [NUM_RO*32-1:0]  status_in
);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state_reg, w_state_next;
    r_state_t    r_state_reg, r_state_next;

    logic        aw_held_reg, w_held_reg;
    logic [5:0]  aw_idx_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  bresp_reg;
    logic [31:0] rdata_reg;

    logic        aw_fire, w_fire, commit;
    logic [5:0]  commit_idx, rd_idx;
    logic [31:0] commit_data, rd_word;
    logic        commit_is_rw;

    logic [31:0] regs_reg    [NUM_RW];
    logic [31:0] status_words[NUM_RO];
    logic [NUM_RW-1:0] wr_sel;
    logic [NUM_RW-1:0] pulse_reg;

    assign aw_fire = (w_state_reg == W_IDLE) && !aw_held_reg && axi.awvalid;
    assign w_fire  = (w_state_reg == W_IDLE) && !w_held_reg && axi.wvalid;

    // A held channel takes precedence; otherwise the live bus value is committing this edge.
    assign commit_idx   = aw_held_reg ? aw_idx_reg : axi.awaddr[7:2];
    assign commit_data  = w_held_reg ? wdata_reg : axi.wdata;
    assign commit_is_rw = {1'b0, commit_idx} < 7'(NUM_RW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_reg <= W_IDLE;
            r_state_reg <= R_IDLE;
        end else begin
            w_state_reg <= w_state_next;
            r_state_reg <= r_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        axi.awready  = 1'b0;
        axi.wready   = 1'b0;
        axi.bvalid   = 1'b0;
        commit       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                axi.awready = !aw_held_reg;
                axi.wready  = !w_held_reg;
                if ((aw_held_reg || axi.awvalid) && (w_held_reg || axi.wvalid)) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready)
                    w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_idx_reg  <= '0;
            wdata_reg   <= '0;
            bresp_reg   <= 2'b00;
        end else if (commit) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
`ifdef AXI_REGS_DECERR_EN
            bresp_reg   <= commit_is_rw ? 2'b00 : 2'b10;
`else
            bresp_reg   <= 2'b00;
`endif
        end else begin
            if (aw_fire) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= axi.awaddr[7:2];
            end
            if (w_fire) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= axi.wdata;
            end
        end
    end

    assign axi.bresp = bresp_reg;

    generate
        for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw
            assign wr_sel[gi] = commit && commit_is_rw && (commit_idx == 6'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi]  <= '0;
                    pulse_reg[gi] <= 1'b0;
                end else begin
                    pulse_reg[gi] <= wr_sel[gi];
                    if (wr_sel[gi])
                        regs_reg[gi] <= commit_data;
                end
            end

            assign reg_out[32*gi +: 32] = regs_reg[gi];
        end

        for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_ro
            assign status_words[gi] = status_in[32*gi +: 32];
        end
    endgenerate

    assign reg_wr_pulse = pulse_reg;

    // Unmapped word offsets read back as zero.
    assign rd_idx = axi.araddr[7:2];
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_RW; i++)
            if (rd_idx == 6'(i)) rd_word = regs_reg[i];
        for (int i = 0; i < NUM_RO; i++)
            if (rd_idx == 6'(NUM_RW + i)) rd_word = status_words[i];
    end

    always_comb begin
        r_state_next = r_state_reg;
        axi.arready  = 1'b0;
        axi.rvalid   = 1'b0;
        axi.rlast    = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                axi.arready = 1'b1;
                if (axi.arvalid)
                    r_state_next = R_DATA;
            end
            R_DATA: begin
                axi.rvalid = 1'b1;
                axi.rlast  = 1'b1;
                if (axi.rready)
                    r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Sampled at the AR handshake so later register/status changes cannot disturb a pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata_reg <= '0;
        else if (r_state_reg == R_IDLE && axi.arvalid)
            rdata_reg <= rd_word;
    end

    assign axi.rdata = rdata_reg;

    logic unused_bits;
    assign unused_bits = ^{axi.wlast, axi.awaddr[31:8], axi.awaddr[1:0],
                           axi.araddr[31:8], axi.araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized bench for axi_lite_reg_slave against a word-array reference model.
// Build with AXI_REGS_DECERR_EN defined to exercise the SLVERR write response.
module tb_axi_lite_reg_slave;
    localparam int NUM_RW = 4;
    localparam int NUM_RO = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_RW*32-1:0] reg_out;
    logic [NUM_RW-1:0]    reg_wr_pulse;
    logic [NUM_RO*32-1:0] status_in = '0;

    axi_lite_if axi_bus ();

    axi_lite_reg_slave #(.NUM_RW(NUM_RW), .NUM_RO(NUM_RO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .axi          (axi_bus.slave),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse),
        .status_in    (status_in)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] mdl_regs [NUM_RW];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        idx = int'(addr[7:2]);
        if (idx < NUM_RW) return mdl_regs[idx];
        if (idx < NUM_RW + NUM_RO) return status_in[32*(idx-NUM_RW) +: 32];
        return 32'h0;
    endfunction

    function automatic logic [1:0] model_bresp(input logic [31:0] addr);
`ifdef AXI_REGS_DECERR_EN
        return (int'(addr[7:2]) < NUM_RW) ? 2'b00 : 2'b10;
`else
        return (addr[7:2] == addr[7:2]) ? 2'b00 : 2'b00;
`endif
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_RW; i++)
            check(tag, reg_out[32*i +: 32], mdl_regs[i]);
    endtask

    // aw_dly / w_dly: cycles before each channel goes valid; b_dly: cycles bready stays low.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic aw_done, w_done, aw_hs, w_hs;
        int cyc, idx;
        logic [3:0] exp_pulse;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        idx     = int'(addr[7:2]);
        axi_bus.bready = (b_dly == 0);
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= aw_dly) begin
                axi_bus.awvalid = 1'b1;
                axi_bus.awaddr  = addr;
            end
            if (!w_done && cyc >= w_dly) begin
                axi_bus.wvalid = 1'b1;
                axi_bus.wdata  = data;
                axi_bus.wlast  = 1'($urandom);
            end
            @(negedge clk);
            aw_hs = axi_bus.awvalid && axi_bus.awready;
            w_hs  = axi_bus.wvalid && axi_bus.wready;
            check("wr_wait_bvalid", 32'(axi_bus.bvalid), 32'd0);
            if (w_done && !aw_done) check("w_held_wready", 32'(axi_bus.wready), 32'd0);
            if (aw_done && !w_done) check("aw_held_awready", 32'(axi_bus.awready), 32'd0);
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1'b1; axi_bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; axi_bus.wvalid  = 1'b0; end
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            check("wr_timeout", 32'd0, 32'd1);
            axi_bus.awvalid = 1'b0;
            axi_bus.wvalid  = 1'b0;
            return;
        end
        exp_pulse = '0;
        if (idx < NUM_RW) begin
            mdl_regs[idx] = data;
            exp_pulse[idx] = 1'b1;
        end
        check("bvalid_latency", 32'(axi_bus.bvalid), 32'd1);
        check("bresp", 32'(axi_bus.bresp), 32'(model_bresp(addr)));
        check("wr_pulse", 32'(reg_wr_pulse), 32'(exp_pulse));
        check_regs("reg_out_after_wr");
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); #1;
            check("bvalid_hold", 32'(axi_bus.bvalid), 32'd1);
            check("awready_in_resp", 32'(axi_bus.awready), 32'd0);
            check("pulse_one_cycle", 32'(reg_wr_pulse), 32'd0);
        end
        axi_bus.bready = 1'b1;
        @(posedge clk); #1;
        axi_bus.bready = 1'b0;
        check("bvalid_drop", 32'(axi_bus.bvalid), 32'd0);
        check("ready_back", 32'({axi_bus.awready, axi_bus.wready}), 32'd3);
        check("pulse_clear", 32'(reg_wr_pulse), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly, input logic chg_status);
        logic [31:0] exp;
        axi_bus.arvalid = 1'b1;
        axi_bus.araddr  = addr;
        @(negedge clk);
        check("arready_idle", 32'(axi_bus.arready), 32'd1);
        exp = model_read(addr);
        @(posedge clk); #1;
        axi_bus.arvalid = 1'b0;
        check("rvalid", 32'(axi_bus.rvalid), 32'd1);
        check("rlast", 32'(axi_bus.rlast), 32'd1);
        check("rdata", axi_bus.rdata, exp);
        check("arready_busy", 32'(axi_bus.arready), 32'd0);
        for (int k = 0; k < r_dly; k++) begin
            if (chg_status) status_in = {$urandom, $urandom};
            @(posedge clk); #1;
            check("rdata_hold", axi_bus.rdata, exp);
            check("rvalid_hold", 32'(axi_bus.rvalid), 32'd1);
        end
        axi_bus.rready = 1'b1;
        @(posedge clk); #1;
        axi_bus.rready = 1'b0;
        check("rvalid_drop", 32'({axi_bus.rvalid, axi_bus.rlast}), 32'd0);
        check("arready_back", 32'(axi_bus.arready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_val, addr;
        int idx;
        axi_bus.awaddr = '0; axi_bus.awvalid = 1'b0;
        axi_bus.wdata = '0;  axi_bus.wlast = 1'b0; axi_bus.wvalid = 1'b0;
        axi_bus.bready = 1'b0;
        axi_bus.araddr = '0; axi_bus.arvalid = 1'b0; axi_bus.rready = 1'b0;
        for (int i = 0; i < NUM_RW; i++) mdl_regs[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'({axi_bus.awready, axi_bus.wready, axi_bus.arready}), 32'd7);
        check("rst_valid", 32'({axi_bus.bvalid, axi_bus.rvalid, axi_bus.rlast}), 32'd0);
        check("rst_rdata", axi_bus.rdata, 32'd0);
        check("rst_bresp", 32'(axi_bus.bresp), 32'd0);
        check("rst_pulse", 32'(reg_wr_pulse), 32'd0);
        check_regs("rst_reg_out");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_read(32'h00, 0, 1'b0);
        do_write(32'h04, 32'hDEADBEEF, 0, 0, 0);
        do_write(32'h08, 32'h12345678, 3, 0, 0);
        do_write(32'h0C, 32'hA5A5_0F0F, 0, 2, 3);
        status_in[31:0] = 32'hCAFE0001;
        do_read(32'h10, 5, 1'b1);
        do_write(32'h3C, 32'hFFFF_FFFF, 0, 0, 0);
        do_write(32'h14, 32'h0BAD_F00D, 1, 0, 1);
        do_read(32'h04, 1, 1'b0);
        do_read(32'hFFFF_FF0B, 0, 1'b0);

        // AR on the same edge as a write commit to that register sees the old value.
        old_val = mdl_regs[0];
        axi_bus.awaddr = 32'h0; axi_bus.wdata = 32'h5555_AAAA; axi_bus.araddr = 32'h0;
        axi_bus.awvalid = 1'b1; axi_bus.wvalid = 1'b1; axi_bus.arvalid = 1'b1;
        axi_bus.bready = 1'b1;
        @(posedge clk); #1;
        axi_bus.awvalid = 1'b0; axi_bus.wvalid = 1'b0; axi_bus.arvalid = 1'b0;
        mdl_regs[0] = 32'h5555_AAAA;
        check("rw_same_edge_old", axi_bus.rdata, old_val);
        check("rw_same_edge_bvalid", 32'(axi_bus.bvalid), 32'd1);
        check_regs("rw_same_edge_regs");
        axi_bus.rready = 1'b1;
        @(posedge clk); #1;
        axi_bus.rready = 1'b0; axi_bus.bready = 1'b0;
        check("rw_same_edge_done", 32'({axi_bus.bvalid, axi_bus.rvalid}), 32'd0);

        for (int n = 0; n < 40; n++) begin
            idx  = int'($urandom_range(0, 15));
            addr = ($urandom & 32'hFFFF_FF03) | 32'(idx << 2);
            status_in = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)));
            else
                do_read(addr, int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Reset while both responses are pending.
        axi_bus.awaddr = 32'h4; axi_bus.wdata = 32'h1111_2222; axi_bus.araddr = 32'h4;
        axi_bus.awvalid = 1'b1; axi_bus.wvalid = 1'b1; axi_bus.arvalid = 1'b1;
        @(posedge clk); #1;
        axi_bus.awvalid = 1'b0; axi_bus.wvalid = 1'b0; axi_bus.arvalid = 1'b0;
        check("pre_rst_valids", 32'({axi_bus.bvalid, axi_bus.rvalid}), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_RW; i++) mdl_regs[i] = '0;
        check("async_rst_valids", 32'({axi_bus.bvalid, axi_bus.rvalid, axi_bus.rlast}), 32'd0);
        check("async_rst_ready", 32'({axi_bus.awready, axi_bus.wready, axi_bus.arready}), 32'd7);
        check_regs("async_rst_regs");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_write(32'h0C, 32'h7777_8888, 0, 0, 0);
        do_read(32'h0C, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
